// File: rtl/mch_rx_deframer.sv
// Manchester receive deframer: collects HDR, L, payload[L], CHK from the decoded
// bit stream and delivers the payload as a byte stream and a packed bus.
module mch_rx_deframer #(
    parameter logic [7:0] HDR     = 8'hCC,
    parameter int         MAX_LEN = 4,
    parameter int         LW      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pls1m,
    input  logic                   sy_ok,
    input  logic                   rcv_sd,
    output logic                   done,
    output logic [LW-1:0]          length,
    output logic [8*MAX_LEN-1:0]   pd,
    output logic [7:0]             rx_byte,
    output logic                   rx_bvalid,
    output logic                   hdr_err,
    output logic                   len_err,
    output logic                   chk_err,
    output logic [7:0]             err_cnt,
    output logic [2:0]             dbg_state
);

    // Handshake: there is no backpressure. rx_bvalid, done and the *_err outputs
    // are single-cycle strobes; rx_byte is meaningful only while rx_bvalid is high,
    // and pd/length are meaningful from the cycle done is high until the next done.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    state_t               state_q, state_d;
    logic                 sy0_q, sy1_q, pl0_q, pl1_q;
    logic [2:0]           bcnt_q, bcnt_d;
    logic [7:0]           sh_q, sh_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [7:0]           cs_q, cs_d;
    logic [8*MAX_LEN-1:0] stg_q, stg_d;
    logic                 done_q, done_d;
    logic [LW-1:0]        length_q, length_d;
    logic [8*MAX_LEN-1:0] pd_q, pd_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 rx_bvalid_q, rx_bvalid_d;
    logic                 hdr_err_q, hdr_err_d;
    logic                 len_err_q, len_err_d;
    logic                 chk_err_q, chk_err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic                 bit_ev, sync_ev;
    logic [7:0]           byte_w;

    assign bit_ev  = pl0_q & ~pl1_q;
    assign sync_ev = sy0_q & ~sy1_q;
    assign byte_w  = {sh_q[6:0], rcv_sd};

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        sh_d        = sh_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cs_d        = cs_q;
        stg_d       = stg_q;
        length_d    = length_q;
        pd_d        = pd_q;
        rx_byte_d   = rx_byte_q;
        done_d      = 1'b0;
        rx_bvalid_d = 1'b0;
        hdr_err_d   = 1'b0;
        len_err_d   = 1'b0;
        chk_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;

        // A sync edge always restarts framing and swallows a coincident bit.
        if (sync_ev) begin
            state_d = S_HDR;
            bcnt_d  = 3'd0;
        end else if (bit_ev && state_q != S_IDLE) begin
            sh_d   = byte_w;
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
                case (state_q)
                    S_HDR: begin
                        if (byte_w == HDR) begin
                            state_d = S_LEN;
                        end else begin
                            hdr_err_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                    S_LEN: begin
                        if (byte_w == 8'd0 || byte_w > MAX_B) begin
                            len_err_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            len_d   = LW'(byte_w);
                            cs_d    = byte_w;
                            idx_d   = '0;
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (idx_q == LW'(k)) stg_d[8*k +: 8] = byte_w;
                        end
                        cs_d        = cs_q ^ byte_w;
                        rx_byte_d   = byte_w;
                        rx_bvalid_d = 1'b1;
                        idx_d       = idx_q + LW'(1);
                        if (idx_q + LW'(1) == len_q) state_d = S_CHK;
                    end
                    S_CHK: begin
                        if (byte_w == cs_q) begin
                            done_d   = 1'b1;
                            length_d = len_q;
                            // Bytes beyond L may be stale from an older frame.
                            for (int k = 0; k < MAX_LEN; k++) begin
                                pd_d[8*k +: 8] = (LW'(k) < len_q) ? stg_q[8*k +: 8] : 8'd0;
                            end
                        end else begin
                            chk_err_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        if ((hdr_err_d | len_err_d | chk_err_d) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Edge registers reset high so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sy0_q       <= 1'b1;
            sy1_q       <= 1'b1;
            pl0_q       <= 1'b1;
            pl1_q       <= 1'b1;
            bcnt_q      <= 3'd0;
            sh_q        <= 8'd0;
            len_q       <= '0;
            idx_q       <= '0;
            cs_q        <= 8'd0;
            stg_q       <= '0;
            done_q      <= 1'b0;
            length_q    <= '0;
            pd_q        <= '0;
            rx_byte_q   <= 8'd0;
            rx_bvalid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            chk_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sy0_q       <= sy_ok;
            sy1_q       <= sy0_q;
            pl0_q       <= pls1m;
            pl1_q       <= pl0_q;
            bcnt_q      <= bcnt_d;
            sh_q        <= sh_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cs_q        <= cs_d;
            stg_q       <= stg_d;
            done_q      <= done_d;
            length_q    <= length_d;
            pd_q        <= pd_d;
            rx_byte_q   <= rx_byte_d;
            rx_bvalid_q <= rx_bvalid_d;
            hdr_err_q   <= hdr_err_d;
            len_err_q   <= len_err_d;
            chk_err_q   <= chk_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign done      = done_q;
    assign length    = length_q;
    assign pd        = pd_q;
    assign rx_byte   = rx_byte_q;
    assign rx_bvalid = rx_bvalid_q;
    assign hdr_err   = hdr_err_q;
    assign len_err   = len_err_q;
    assign chk_err   = chk_err_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mch_rx_deframer.md
Name: mch_rx_deframer

Overview:
- Parametrised next-generation Manchester receive serial-to-parallel deframer.
- Sits after the Manchester decoder / sync detector; consumes the decoded bit stream (rcv_sd), the bit strobe (pls1m) and the sync indication (sy_ok).
- Supports a variable payload of 1..MAX_LEN bytes, a programmable header, and an XOR checksum; reports header/length/checksum errors.
- Delivers the payload both as a per-byte stream and as a packed parallel bus.

Parameters:
- HDR, 8'hCC, required header byte value.
- MAX_LEN, 4, maximum payload bytes (1..32).
- LW, 6, width of length field/counters; must satisfy 2^LW > MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- pls1m  in  1  bit strobe from decoder; a rising edge marks a valid rcv_sd bit.
- sy_ok  in  1  sync detected; a rising edge starts a frame.
- rcv_sd  in  1  decoded serial data, MSB first.
- done  out  1  one-cycle pulse, good frame received.
- length  out  LW  payload length of the last good frame.
- pd  out  8*MAX_LEN  payload of the last good frame; byte k at [8k+7:8k].
- rx_byte  out  8  current payload byte (stream).
- rx_bvalid  out  1  one-cycle pulse qualifying rx_byte.
- hdr_err  out  1  one-cycle pulse, header mismatch.
- len_err  out  1  one-cycle pulse, length 0 or >MAX_LEN.
- chk_err  out  1  one-cycle pulse, checksum mismatch.
- err_cnt  out  8  saturating count of all error pulses.

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; bit counter 0; shift register 0. Input-edge registers sy0/sy1/pl0/pl1 reset to 1 so that no false edge occurs on release.
- pls1m and sy_ok are registered twice (x0, x1). bit_ev = pl0&~pl1; sync_ev = sy0&~sy1.
- On bit_ev, rcv_sd is shifted in: sh <= {sh[6:0],rcv_sd}. The byte is complete on the 8th bit_ev; the completed byte is {sh[6:0],rcv_sd}, used in the same cycle.
- Frame format: HDR, L, payload[0..L-1], CHK, where CHK = L ^ payload[0] ^ ... ^ payload[L-1].
- State machine:
  - IDLE: ignores bit_ev. On sync_ev: bit counter 0, go to HDR.
  - HDR: on byte complete, go to LEN if the byte == HDR. Otherwise pulse hdr_err and go to IDLE.
  - LEN: on byte complete with value L (zero-extended/truncated to LW):
    - If 1 <= L <= MAX_LEN: latch L, init checksum to L, byte index 0, go to DATA.
    - If the 8-bit value is 0 or > MAX_LEN: pulse len_err and go to IDLE.
  - DATA: on each byte complete:
    - Store it into the staging buffer at index i.
    - XOR it into the checksum.
    - Drive rx_byte = byte and pulse rx_bvalid in the following cycle.
    - i+1 == L -> go to CHK.
  - CHK: on byte complete:
    - If byte == checksum: length <= L; pd <= staging buffer with bytes at index >= L forced 0; done pulses. pd, length and done update on the same edge.
    - Else pulse chk_err; pd and length unchanged.
    - Either way go to IDLE.
- Output timing: rx_bvalid, done and all *_err pulses are registered; each is high exactly 1 clk, starting the clock after the completing bit_ev cycle.
- sync_ev in any state, including mid-frame: silently abort the current frame (no error, no pulse) and restart in HDR with bit counter 0. The staging buffer is not cleared; pd and length are not disturbed.
- sync_ev and bit_ev in the same cycle: sync_ev wins; that bit is not counted.
- err_cnt increments by 1 per error pulse and saturates at 255. Only one error can occur per cycle.
- pd/length hold until the next good frame or reset.

Test Plan:
- MAX_LEN=4, HDR=CC. Sync edge, then bytes CC 04 11 22 33 44 40 -> 4 rx_bvalid pulses (11,22,33,44); done 1 clk; length=4; pd=32'h44332211; no errors.
- Bytes CC 02 A5 5A FD -> 2 rx_bvalid pulses; done; length=2; pd=32'h00005AA5 (upper bytes zeroed after the previous frame).
- Bytes CD 04 ... -> hdr_err pulse after byte 0; no rx_bvalid; err_cnt=1; pd unchanged.
- Bytes CC 05 ... and CC 00 ... -> len_err pulse each; err_cnt +2; state IDLE (subsequent bits ignored until sync).
- Bytes CC 02 A5 5A 00 -> 2 rx_bvalid pulses, chk_err pulse, no done, pd/length keep previous values.
- Sync edge mid-DATA, then a complete good frame -> no error, done only for the second frame. Assert rst low mid-frame -> all outputs 0 immediately. Force 256 errors -> err_cnt stays at 255.
